program_counter: RTL and testbench
==================================

// Module: program_counter
// PURPOSE
//   Fetch-address generator built around an N-bit state register.
//   Presents the current fetch address with a valid/ready handshake and
//   advances by STEP on each accepted transfer.
//   Accepts redirects (branch/jump) via load/in, and supports halting.
//   Sits directly upstream of the instruction fetch stage.
// PARAMETERS
//   N             32     address width
//   STEP          4      increment per accepted address; power of two, >= 1
//   RESET_VECTOR  0      first address after reset
//   TRAP_VECTOR   'h10   redirect target on misaligned load (optional feature only)
// PORTS
//   clk        in   1  clock; all state updates on posedge
//   rst_n      in   1  reset, synchronous, active-low
//   load       in   1  redirect request; takes effect at next posedge
//   in         in   N  redirect target address
//   halt       in   1  stop issuing addresses while high
//   out        out  N  current fetch address
//   out_valid  out  1  out holds a valid address
//   out_ready  in   1  consumer accepts out this cycle
//   trap       out  1  one-cycle pulse on misaligned redirect (optional feature only; else tied 0)
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): out=RESET_VECTOR, out_valid=0, trap=0, state=BOOT.
//     Reset overrides every other input, including mid-handshake or mid-bubble.
//   - fire = out_valid & out_ready.
//   - States: BOOT, RUN, BUBBLE, HALTED.
//     BOOT   -> RUN next cycle, out_valid=1 (halt=1 -> HALTED instead, out_valid=0).
//     RUN    fire & !load: out <= out+STEP (mod 2^N wrap), out_valid stays 1.
//            load (any fire): out <= in, out_valid <= 0, -> BUBBLE.
//              A same-cycle fire completes with the old address.
//            halt & (fire | !out_valid) & !load: out <= out+STEP if fire,
//              out_valid <= 0, -> HALTED.
//            out_valid & !out_ready & !load: out and out_valid held stable.
//              Halt is ignored until fire.
//     BUBBLE -> RUN with out_valid=1, exactly one bubble cycle after load.
//            load in BUBBLE: out <= in, stay BUBBLE.
//            halt in BUBBLE: -> HALTED.
//     HALTED out_valid=0; load updates out, stays HALTED.
//            halt=0 -> RUN, out_valid=1 next cycle.
//   - Priority: rst_n > load > halt > fire/increment.
//   - Latency: load-to-valid = 2 cycles (bubble, then valid). Reset-to-valid = 2 cycles.
//   - Wrap: out = 2^N-STEP with fire -> out = 0, no flag.
//   - out never changes while out_valid=1 & out_ready=0, except via load or reset.
// CONFIGURATION
//   PC_ALIGN_CHECK_EN defined:
//     load with in[log2(STEP)-1:0] != 0 -> out <= TRAP_VECTOR, trap=1 for one cycle.
//     State sequencing is otherwise identical (BUBBLE).
//   PC_ALIGN_CHECK_EN undefined:
//     in is loaded verbatim, trap tied 0, TRAP_VECTOR unused.
// TESTING
//   1. rst_n=0 for 2 cycles, then 1, out_ready=1
//      -> cycle +1 out=0 valid=1; then out=4, 8, 12 on successive cycles.
//   2. out_ready=0 for 5 cycles at out=8
//      -> out=8, out_valid=1 stable throughout; out_ready=1 -> next out=12.
//   3. load=1, in='h200, same-cycle fire at out=12
//      -> 12 accepted; next cycle valid=0; then out='h200, valid=1.
//   4. Start at out='hFFFF_FFFC, fire
//      -> out=0; assert halt -> valid=0; load 'h40 while halted, release halt
//      -> out='h40, valid=1.
//   5. PC_ALIGN_CHECK_EN defined, load in='h203
//      -> trap=1 for one cycle, out='h10 after bubble.
//      Macro undefined -> out='h203, trap=0.
//   6. rst_n=0 during BUBBLE and during stalled handshake
//      -> next cycle out=0, valid=0, state=BOOT.

Source files
------------

// File: rtl/program_counter_if.sv
// rtl/program_counter_if.sv - fetch-address handshake bundle between program_counter and its consumer
interface program_counter_if #(
  parameter int unsigned N = 32
) ();

  logic         load;
  logic [N-1:0] in;
  logic         halt;
  logic [N-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         trap;

  // Address generator side: takes redirect/halt/ready, drives the fetch address.
  modport master (
    input  load,
    input  in,
    input  halt,
    input  out_ready,
    output out,
    output out_valid,
    output trap
  );

  // Fetch-stage side: issues redirects/halts, consumes the fetch address.
  modport slave (
    output load,
    output in,
    output halt,
    output out_ready,
    input  out,
    input  out_valid,
    input  trap
  );

endinterface

// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch-address generator with valid/ready handshake, redirect and halt; optional misalignment trap under PC_ALIGN_CHECK_EN
module program_counter #(
  parameter int unsigned  N            = 32,
  parameter int unsigned  STEP         = 4,
  parameter logic [N-1:0] RESET_VECTOR = '0,
  parameter logic [N-1:0] TRAP_VECTOR  = N'('h10)
) (
  input  logic              clk,
  input  logic              rst_n,
  program_counter_if.master bus
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_BUBBLE = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  // STEP is a power of two, so the low address bits it spans must be zero
  // for an aligned target. A mask form also covers STEP == 1 (empty mask).
  localparam logic [N-1:0] STEP_V     = N'(STEP);
  localparam logic [N-1:0] ALIGN_MASK = N'(STEP - 1);

  logic [1:0]   state_q, state_d;
  logic [N-1:0] out_q,   out_d;
  logic         valid_q, valid_d;
  logic         trap_q,  trap_d;

  logic         fire;
  logic [N-1:0] out_inc;
  logic [N-1:0] load_addr;
  logic         load_trap;

  assign fire    = valid_q & bus.out_ready;
  assign out_inc = out_q + STEP_V;

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned;

  // Misaligned redirect targets are replaced by the trap vector and flagged.
  always_comb begin
    misaligned = |(bus.in & ALIGN_MASK);
    load_addr  = misaligned ? TRAP_VECTOR : bus.in;
    load_trap  = misaligned;
  end
`else
  logic unused_trap_vector;

  // Redirect targets are taken verbatim; TRAP_VECTOR has no effect in this build.
  always_comb begin
    load_addr = bus.in;
    load_trap = 1'b0;
  end

  assign unused_trap_vector = ^{TRAP_VECTOR, ALIGN_MASK};
`endif

  // Next-state decode: load beats halt beats the plain increment.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    valid_d = valid_q;
    trap_d  = 1'b0;

    if (bus.load) begin
      // A fire in the same cycle still completes with the old address;
      // the consumer sees one bubble before the new target.
      out_d   = load_addr;
      valid_d = 1'b0;
      trap_d  = load_trap;
      state_d = (state_q == ST_HALTED) ? ST_HALTED : ST_BUBBLE;
    end else begin
      case (state_q)
        ST_BOOT, ST_BUBBLE: begin
          if (bus.halt) begin
            valid_d = 1'b0;
            state_d = ST_HALTED;
          end else begin
            valid_d = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          // A presented address must be taken before halt can retire it,
          // so halt only acts on a fire or with nothing on offer.
          if (bus.halt && (fire || !valid_q)) begin
            if (fire) begin
              out_d = out_inc;
            end
            valid_d = 1'b0;
            state_d = ST_HALTED;
          end else if (fire) begin
            out_d = out_inc;
          end
        end
        ST_HALTED: begin
          valid_d = 1'b0;
          if (!bus.halt) begin
            valid_d = 1'b1;
            state_d = ST_RUN;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      out_q   <= RESET_VECTOR;
      valid_q <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      trap_q  <= trap_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.trap      = trap_q;

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - self-checking bench for program_counter (directed scenarios plus randomized run against a reference model)
module tb_program_counter;

  localparam int unsigned N = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  program_counter_if #(.N(N)) bus ();

  program_counter #(
    .N            (N),
    .STEP         (4),
    .RESET_VECTOR (32'h0),
    .TRAP_VECTOR  (32'h10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  // Reference model: a fetcher is either booting, waiting out a bubble,
  // halted, or streaming; addresses advance by 4 per accepted transfer.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_trap;
  bit          m_boot;
  bit          m_bubble;
  bit          m_halted;

  task automatic model_update();
    bit accepted;
    bit bad;
    accepted = m_valid && bus.out_ready;
    m_trap   = 1'b0;
    if (!rst_n) begin
      m_pc = 32'h0; m_valid = 1'b0;
      m_boot = 1; m_bubble = 0; m_halted = 0;
    end else if (bus.load) begin
      bad     = ALIGN_EN && (bus.in % 4 != 0);
      m_pc    = bad ? 32'h10 : bus.in;
      m_trap  = bad;
      m_valid = 1'b0;
      m_boot  = 0;
      if (!m_halted) m_bubble = 1;
    end else if (m_halted) begin
      if (!bus.halt) begin
        m_halted = 0; m_valid = 1'b1;
      end
    end else if (m_boot || m_bubble) begin
      m_boot = 0; m_bubble = 0;
      if (bus.halt) m_halted = 1;
      else m_valid = 1'b1;
    end else begin
      if (accepted) m_pc = m_pc + 32'd4;
      if (bus.halt && (accepted || !m_valid)) begin
        m_valid = 1'b0; m_halted = 1;
      end
    end
  endtask

  // One clock: inputs stay put across the edge, outputs sampled at negedge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.out_ready = 1'b1;
    step(); step();
    checks++; if (bus.out !== 32'h0) $display("FAIL reset_out: got %h expected %h", bus.out, 32'h0); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.out_valid); else passed++;
    checks++; if (bus.trap !== 1'b0) $display("FAIL reset_trap: got %b expected 0", bus.trap); else passed++;
    rst_n = 1'b1;
    step();
    checks++; if (bus.out !== 32'h0 || bus.out_valid !== 1'b1) $display("FAIL boot_first: got %h/%b expected 00000000/1", bus.out, bus.out_valid); else passed++;
    step();
    checks++; if (bus.out !== 32'h4 || bus.out_valid !== 1'b1) $display("FAIL seq_4: got %h/%b expected 00000004/1", bus.out, bus.out_valid); else passed++;
    step();
    checks++; if (bus.out !== 32'h8 || bus.out_valid !== 1'b1) $display("FAIL seq_8: got %h/%b expected 00000008/1", bus.out, bus.out_valid); else passed++;
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.out !== 32'h8 || bus.out_valid !== 1'b1) $display("FAIL stall_hold[%0d]: got %h/%b expected 00000008/1", i, bus.out, bus.out_valid); else passed++;
    end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out !== 32'hc || bus.out_valid !== 1'b1) $display("FAIL stall_release: got %h/%b expected 0000000c/1", bus.out, bus.out_valid); else passed++;
  endtask

  task automatic test_load();
    checks++; if (!(bus.out === 32'hc && bus.out_valid === 1'b1)) $display("FAIL load_pre: got %h/%b expected 0000000c/1", bus.out, bus.out_valid); else passed++;
    bus.load = 1'b1; bus.in = 32'h200; bus.out_ready = 1'b1;
    step();
    bus.load = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL load_bubble: got valid %b expected 0", bus.out_valid); else passed++;
    step();
    checks++; if (bus.out !== 32'h200 || bus.out_valid !== 1'b1) $display("FAIL load_target: got %h/%b expected 00000200/1", bus.out, bus.out_valid); else passed++;
  endtask

  task automatic test_wrap_halt();
    bus.out_ready = 1'b0;
    bus.load = 1'b1; bus.in = 32'hffff_fffc;
    step();
    bus.load = 1'b0;
    step();
    checks++; if (bus.out !== 32'hffff_fffc || bus.out_valid !== 1'b1) $display("FAIL wrap_pre: got %h/%b expected fffffffc/1", bus.out, bus.out_valid); else passed++;
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out !== 32'h0 || bus.out_valid !== 1'b1) $display("FAIL wrap_zero: got %h/%b expected 00000000/1", bus.out, bus.out_valid); else passed++;
    bus.halt = 1'b1;
    step();
    checks++; if (bus.out !== 32'h4 || bus.out_valid !== 1'b0) $display("FAIL halt_enter: got %h/%b expected 00000004/0", bus.out, bus.out_valid); else passed++;
    bus.load = 1'b1; bus.in = 32'h40;
    step();
    bus.load = 1'b0;
    checks++; if (bus.out !== 32'h40 || bus.out_valid !== 1'b0) $display("FAIL halt_load: got %h/%b expected 00000040/0", bus.out, bus.out_valid); else passed++;
    step();
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL halt_stay: got valid %b expected 0", bus.out_valid); else passed++;
    bus.halt = 1'b0;
    step();
    checks++; if (bus.out !== 32'h40 || bus.out_valid !== 1'b1) $display("FAIL halt_release: got %h/%b expected 00000040/1", bus.out, bus.out_valid); else passed++;
  endtask

  task automatic test_align();
    logic [31:0] exp_addr;
    exp_addr = ALIGN_EN ? 32'h10 : 32'h203;
    bus.out_ready = 1'b1;
    bus.load = 1'b1; bus.in = 32'h203;
    step();
    bus.load = 1'b0;
    checks++; if (bus.trap !== ALIGN_EN) $display("FAIL align_trap: got %b expected %b", bus.trap, ALIGN_EN); else passed++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL align_bubble: got valid %b expected 0", bus.out_valid); else passed++;
    step();
    checks++; if (bus.trap !== 1'b0) $display("FAIL align_trap_pulse: got %b expected 0", bus.trap); else passed++;
    checks++; if (bus.out !== exp_addr || bus.out_valid !== 1'b1) $display("FAIL align_target: got %h/%b expected %h/1", bus.out, bus.out_valid, exp_addr); else passed++;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    bus.load = 1'b1; bus.in = 32'h300;
    step();
    bus.load = 1'b0; rst_n = 1'b0;
    step();
    checks++; if (bus.out !== 32'h0 || bus.out_valid !== 1'b0 || bus.trap !== 1'b0) $display("FAIL rst_bubble: got %h/%b/%b expected 00000000/0/0", bus.out, bus.out_valid, bus.trap); else passed++;
    rst_n = 1'b1;
    step();
    checks++; if (bus.out !== 32'h0 || bus.out_valid !== 1'b1) $display("FAIL rst_bubble_boot: got %h/%b expected 00000000/1", bus.out, bus.out_valid); else passed++;
    step();
    bus.out_ready = 1'b0;
    step();
    checks++; if (bus.out !== 32'h4 || bus.out_valid !== 1'b1) $display("FAIL rst_stall_pre: got %h/%b expected 00000004/1", bus.out, bus.out_valid); else passed++;
    rst_n = 1'b0;
    step();
    checks++; if (bus.out !== 32'h0 || bus.out_valid !== 1'b0) $display("FAIL rst_stall: got %h/%b expected 00000000/0", bus.out, bus.out_valid); else passed++;
    rst_n = 1'b1;
    step();
    checks++; if (bus.out !== 32'h0 || bus.out_valid !== 1'b1) $display("FAIL rst_stall_boot: got %h/%b expected 00000000/1", bus.out, bus.out_valid); else passed++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    rst_n = 1'b0; bus.load = 1'b0; bus.halt = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      rst_n         = ($urandom_range(0, 59) != 0);
      bus.load      = ($urandom_range(0, 7) == 0);
      bus.halt      = ($urandom_range(0, 5) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: bus.in = 32'hffff_fff0 + 32'($urandom_range(0, 3) * 4);
        1: bus.in = $urandom();
        default: bus.in = $urandom() & 32'hffff_fffc;
      endcase
      step();
      if (errs < 10) begin
        checks++; if (bus.out !== m_pc) begin $display("FAIL rand_out[%0d]: got %h expected %h", i, bus.out, m_pc); errs++; end else passed++;
        checks++; if (bus.out_valid !== m_valid) begin $display("FAIL rand_valid[%0d]: got %b expected %b", i, bus.out_valid, m_valid); errs++; end else passed++;
        checks++; if (bus.trap !== m_trap) begin $display("FAIL rand_trap[%0d]: got %b expected %b", i, bus.trap, m_trap); errs++; end else passed++;
      end
    end
    rst_n = 1'b1; bus.load = 1'b0; bus.halt = 1'b0;
  endtask

  initial begin
    checks = 0; passed = 0;
    rst_n = 1'b0;
    bus.load = 1'b0; bus.in = '0; bus.halt = 1'b0; bus.out_ready = 1'b0;
    m_pc = 32'h0; m_valid = 1'b0; m_trap = 1'b0;
    m_boot = 1; m_bubble = 0; m_halted = 0;
    @(negedge clk);
    test_reset();
    test_stall();
    test_load();
    test_wrap_halt();
    test_align();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
